music_player: RTL and testbench

//   Parametrised song sequencer and tone generator for the buzzer path.
//   - Steps through a song stored in an external synchronous note ROM, one slot per beat.
//   - Each ROM word is a full tone period in clk cycles; the block turns it into a
//     50%-duty square wave.
//   - Adds song select, loop, pause, stop, variable song length and rest detection.
//   - Sits between the top-level control FSM and the buzzer pin.

---
 rtl/music_player.sv | 161 ++++++++++++++++
 tb/tb_music_player.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player.sv
// music_player: song sequencer and square-wave tone generator for the buzzer.
//
// Plays one song from an external synchronous note ROM, one slot per beat. Each
// ROM word is a full tone period in clk cycles and becomes a 50%-duty square
// wave. Notes at or below REST_MAX are rests. The block supports song select,
// looping, pause and stop.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   play       1-cycle start pulse, accepted only when idle
//   stop       abort playback; wins over play and pause
//   pause      level; freezes beat and tone timing and silences the buzzer
//   loop_en    level; sampled on the last slot's final beat cycle
//   song_sel   song index, latched on an accepted play
//   last_slot  index of the final slot, latched on an accepted play
//   rom_addr   {song, slot} address; ROM data is expected one cycle later
//   rom_note   ROM read data (tone period in clk cycles)
//   buzzer     registered square-wave output
//   busy       high whenever not idle
//   done       1-cycle pulse when a non-looping song completes
//   cur_slot   index of the slot currently sounding
module music_player #(
    parameter int unsigned NOTE_W     = 17,
    parameter int unsigned SLOT_W     = 8,
    parameter int unsigned SEL_W      = 1,
    parameter int unsigned BEAT_TICKS = 12500000,
    parameter int unsigned REST_MAX   = 4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    play,
    input  logic                    stop,
    input  logic                    pause,
    input  logic                    loop_en,
    input  logic [SEL_W-1:0]        song_sel,
    input  logic [SLOT_W-1:0]       last_slot,
    output logic [SEL_W+SLOT_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0]       rom_note,
    output logic                    buzzer,
    output logic                    busy,
    output logic                    done,
    output logic [SLOT_W-1:0]       cur_slot
);

    localparam int unsigned       BeatW    = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam logic [BeatW-1:0]  BeatLast = BeatW'(BEAT_TICKS - 1);
    localparam logic [NOTE_W-1:0] RestLim  = NOTE_W'(REST_MAX);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StPlay, StDone} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    song_q, song_d;
    logic [SLOT_W-1:0]   last_q, last_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [NOTE_W-1:0]   tone_q, tone_d;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic                buzzer_q, buzzer_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            song_q     <= '0;
            last_q     <= '0;
            slot_q     <= '0;
            cur_slot_q <= '0;
            note_q     <= '0;
            tone_q     <= '0;
            beat_q     <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            last_q     <= last_d;
            slot_q     <= slot_d;
            cur_slot_q <= cur_slot_d;
            note_q     <= note_d;
            tone_q     <= tone_d;
            beat_q     <= beat_d;
            buzzer_q   <= buzzer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        last_d     = last_q;
        slot_d     = slot_q;
        cur_slot_d = cur_slot_q;
        note_d     = note_q;
        tone_d     = tone_q;
        beat_d     = beat_q;
        buzzer_d   = buzzer_q;

        unique case (state_q)
            StIdle: begin
                if (play && !stop) begin
                    song_d  = song_sel;
                    last_d  = last_slot;
                    slot_d  = '0;
                    state_d = StFetch;
                end
            end
            // Address is driven from song_q/slot_q; the ROM answers during WAIT.
            StFetch: state_d = StWait;
            StWait: begin
                // Reloading the tone counter here phase-aligns every note.
                note_d     = rom_note;
                tone_d     = '0;
                beat_d     = '0;
                cur_slot_d = slot_q;
                state_d    = StPlay;
            end
            StPlay: begin
                if (pause) begin
                    buzzer_d = 1'b0;
                end else begin
                    if (note_q > RestLim) begin
                        buzzer_d = (tone_q < (note_q >> 1));
                        tone_d   = (tone_q == note_q - 1'b1) ? '0 : tone_q + 1'b1;
                    end else begin
                        buzzer_d = 1'b0;
                    end
                    if (beat_q == BeatLast) begin
                        if (slot_q != last_q) begin
                            slot_d  = slot_q + 1'b1;
                            state_d = StFetch;
                        end else if (loop_en) begin
                            slot_d  = '0;
                            state_d = StFetch;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StDone: begin
                buzzer_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Stop overrides everything and skips the done pulse.
        if (stop && (state_q != StIdle)) begin
            state_d  = StIdle;
            buzzer_d = 1'b0;
        end
    end

    assign rom_addr = {song_q, slot_q};
    assign buzzer   = buzzer_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign cur_slot = cur_slot_q;

endmodule

// File: tb/tb_music_player.sv
// tb_music_player: directed self-checking bench for music_player.
//
// Runs with BEAT_TICKS=20 and REST_MAX=4 against a 1-cycle synchronous ROM model.
// Inputs change on the falling edge and outputs are sampled there too. In the
// comments, nK is the K-th falling edge after the one where play is driven.
module tb_music_player;

    localparam int unsigned NOTE_W = 17;
    localparam int unsigned SLOT_W = 8;
    localparam int unsigned SEL_W  = 1;
    localparam int unsigned AW     = SEL_W + SLOT_W;

    logic              clk;
    logic              rst;
    logic              play;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [SEL_W-1:0]  song_sel;
    logic [SLOT_W-1:0] last_slot;
    logic [AW-1:0]     rom_addr;
    logic [NOTE_W-1:0] rom_note;
    logic              buzzer;
    logic              busy;
    logic              done;
    logic [SLOT_W-1:0] cur_slot;

    logic [NOTE_W-1:0] rom [2**AW];

    int total;
    int bad;

    music_player #(
        .NOTE_W    (NOTE_W),
        .SLOT_W    (SLOT_W),
        .SEL_W     (SEL_W),
        .BEAT_TICKS(20),
        .REST_MAX  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .stop     (stop),
        .pause    (pause),
        .loop_en  (loop_en),
        .song_sel (song_sel),
        .last_slot(last_slot),
        .rom_addr (rom_addr),
        .rom_note (rom_note),
        .buzzer   (buzzer),
        .busy     (busy),
        .done     (done),
        .cur_slot (cur_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_note <= rom[rom_addr];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2**AW; i++) rom[i] = '0;
        rom[9'h000] = 17'd8;
        rom[9'h001] = 17'd5;
        rom[9'h100] = 17'd10;
        rom[9'h101] = 17'd6;
        rom[9'h102] = 17'd3;

        rst = 1'b1; play = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        song_sel = '0; last_slot = '0;
        step(3);
        rst = 1'b0;
        chk("rst_buzzer", buzzer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur_slot", cur_slot, 0);
        chk("rst_rom_addr", rom_addr, 0);

        // 1: song 1, three slots: period 10, period 6, rest
        song_sel = 1'b1; last_slot = 8'd2; play = 1'b1;
        step(1); play = 1'b0;                                   // n1 FETCH
        chk("t1_busy", busy, 1);
        chk("t1_addr0", rom_addr, 'h100);
        step(2);                                                // n3 first PLAY
        chk("t1_cur0", cur_slot, 0);
        chk("t1_buz_start", buzzer, 0);
        for (int k = 4; k <= 23; k++) begin
            step(1);
            chk("t1_buz_p10", buzzer, 32'(((k - 4) % 10) < 5));
        end
        chk("t1_addr1", rom_addr, 'h101);                       // n23 FETCH
        step(2);
        chk("t1_cur1", cur_slot, 1);
        for (int k = 26; k <= 44; k++) begin
            step(1);
            chk("t1_buz_p6", buzzer, 32'(((k - 26) % 6) < 3));
        end
        step(1);                                                // n45 FETCH
        chk("t1_addr2", rom_addr, 'h102);
        chk("t1_buz_hold", buzzer, 1);
        step(2);
        chk("t1_cur2", cur_slot, 2);
        for (int k = 48; k <= 66; k++) begin
            step(1);
            chk("t1_rest_buz", buzzer, 0);
            chk("t1_rest_done", done, 0);
        end
        step(1);                                                // n67 DONE
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 1);
        step(1);
        chk("t1_done_end", done, 0);
        chk("t1_idle", busy, 0);

        // 2: looping two-slot song, then loop_en cleared during slot 0
        song_sel = 1'b0; last_slot = 8'd1; loop_en = 1'b1; play = 1'b1;
        step(1); play = 1'b0;                                   // n1
        for (int s = 0; s < 5; s++) begin
            chk("t2_addr", rom_addr, 32'(s % 2));
            chk("t2_busy", busy, 1);
            if (s < 4) begin
                for (int c = 0; c < 22; c++) begin
                    step(1);
                    chk("t2_no_done", done, 0);
                end
            end
        end
        step(5);                                                // n94 slot 0 PLAY
        loop_en = 1'b0;
        step(17);                                               // n111 FETCH slot 1
        chk("t2_addr_last", rom_addr, 1);
        chk("t2_no_done_last", done, 0);
        step(22);                                               // n133 DONE
        chk("t2_done", done, 1);
        step(1);
        chk("t2_idle", busy, 0);

        // 3: pause 15 cycles mid-slot, period 8, single slot
        last_slot = 8'd0; play = 1'b1;
        step(1); play = 1'b0;
        step(2);                                                // n3
        for (int k = 4; k <= 8; k++) begin
            step(1);
            chk("t3_buz_pre", buzzer, 32'(((k - 4) % 8) < 4));
        end
        pause = 1'b1;
        for (int k = 9; k <= 23; k++) begin
            step(1);
            chk("t3_buz_paused", buzzer, 0);
            chk("t3_busy_paused", busy, 1);
        end
        pause = 1'b0;
        for (int k = 24; k <= 37; k++) begin
            step(1);
            chk("t3_buz_post", buzzer, 32'(((k - 19) % 8) < 4));
            chk("t3_no_done", done, 0);
        end
        step(1);                                                // n38 DONE
        chk("t3_done", done, 1);
        chk("t3_done_buz", buzzer, 1);
        step(1);
        chk("t3_idle", busy, 0);
        chk("t3_idle_buz", buzzer, 0);

        // 4: stop during PLAY (buzzer high), stop during WAIT, stop+play together
        play = 1'b1;
        step(1); play = 1'b0;
        step(4);                                                // n5
        chk("t4_buz_high", buzzer, 1);
        stop = 1'b1;
        step(1); stop = 1'b0;
        chk("t4_play_stop_busy", busy, 0);
        chk("t4_play_stop_buz", buzzer, 0);
        chk("t4_play_stop_done", done, 0);
        play = 1'b1;
        step(1); play = 1'b0;                                   // n1 FETCH
        step(1);                                                // n2 WAIT
        chk("t4_wait_busy", busy, 1);
        stop = 1'b1;
        step(1); stop = 1'b0;
        chk("t4_wait_stop_busy", busy, 0);
        chk("t4_wait_stop_buz", buzzer, 0);
        for (int c = 0; c < 25; c++) begin
            step(1);
            chk("t4_stay_idle", busy, 0);
            chk("t4_never_done", done, 0);
        end
        play = 1'b1; stop = 1'b1;
        step(1); play = 1'b0; stop = 1'b0;
        chk("t4_dropped_play", busy, 0);
        for (int c = 0; c < 5; c++) begin
            step(1);
            chk("t4_dropped_idle", busy, 0);
        end

        // 5: second play mid-song with other song_sel/last_slot is ignored
        song_sel = 1'b1; last_slot = 8'd2; play = 1'b1;
        step(1); play = 1'b0;
        chk("t5_addr0", rom_addr, 'h100);
        step(4);                                                // n5 PLAY
        song_sel = 1'b0; last_slot = 8'd0; play = 1'b1;
        step(1); play = 1'b0;                                   // n6
        chk("t5_busy", busy, 1);
        chk("t5_addr_kept", rom_addr, 'h100);
        step(17);
        chk("t5_addr1", rom_addr, 'h101);
        step(22);
        chk("t5_addr2", rom_addr, 'h102);
        step(22);                                               // n67
        chk("t5_done", done, 1);
        step(1);
        chk("t5_idle", busy, 0);

        // 6: odd period 7 as a 1-slot song, then reset mid-PLAY
        rom[9'h000] = 17'd7;
        song_sel = 1'b0; last_slot = 8'd0; play = 1'b1;
        step(1); play = 1'b0;
        step(2);                                                // n3
        for (int k = 4; k <= 17; k++) begin
            step(1);
            chk("t6_buz_p7", buzzer, 32'(((k - 4) % 7) < 3));
        end
        step(6);                                                // n23 DONE
        chk("t6_done", done, 1);
        step(1);
        chk("t6_idle", busy, 0);

        song_sel = 1'b1; last_slot = 8'd2; play = 1'b1;
        step(1); play = 1'b0;
        step(26);                                               // n27 slot 1 PLAY
        chk("t6_pre_rst_buz", buzzer, 1);
        chk("t6_pre_rst_cur", cur_slot, 1);
        chk("t6_pre_rst_addr", rom_addr, 'h101);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst_buz", buzzer, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_cur", cur_slot, 0);
        chk("t6_rst_addr", rom_addr, 0);
        step(3);
        chk("t6_rst_stays_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
